// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if
// Load/store port between the core MEM stage and the data-side responder.
//   ena_rd      load strobe
//   ena_wr      store strobe
//   addr        byte address
//   dataram_wr  store data
//   dataram_rd  load data, returned combinationally in the strobe cycle
// The master modport is the core side and the slave modport is the responder side.
interface dmem_mmio_if;
    logic        ena_rd;
    logic        ena_wr;
    logic [31:0] addr;
    logic [31:0] dataram_wr;
    logic [31:0] dataram_rd;

    modport master (
        output ena_rd,
        output ena_wr,
        output addr,
        output dataram_wr,
        input  dataram_rd
    );

    modport slave (
        input  ena_rd,
        input  ena_wr,
        input  addr,
        input  dataram_wr,
        output dataram_rd
    );
endinterface

// File: rtl/dmem_mmio_slave.sv
// dmem_mmio_slave
// Data-side responder for the pipelined core. It provides word-addressed RAM
// plus a peripheral window that holds LEDs, synchronised switches and a
// 32-bit timer with compare and interrupt.
// Reads are combinational so the core can forward load data in MEM.
// Writes commit on the rising clock edge.
// Ports:
//   CLOCK      rising-edge clock
//   RST_n      asynchronous active-low reset
//   bus        load/store port (dmem_mmio_if.slave)
//   sw_in      asynchronous switch inputs
//   leds       LED register
//   timer_irq  level interrupt, match & irq_en
//   bus_err    sticky access-error flag
// Peripheral offsets from MMIO_BASE:
//   0x00 LEDS, 0x04 SW, 0x08 COUNT, 0x0C COMPARE, 0x10 CTRL, 0x14 STATUS
module dmem_mmio_slave #(
    parameter int          RAM_WORDS = 1024,
    parameter int          PRESCALE  = 1,
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    dmem_mmio_if.slave        bus,
    input  logic [9:0]        sw_in,
    output logic [9:0]        leds,
    output logic              timer_irq,
    output logic              bus_err
);

    localparam int              IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0]     RAM_BYTES = 32'(RAM_WORDS) << 2;
    localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(PRESCALE - 1);

    logic [31:0]      ram [RAM_WORDS];
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      off;
    logic             aligned, in_ram, in_mmio, mapped;
    logic             sel_leds, sel_sw, sel_count, sel_cmp, sel_ctrl, sel_status;
    logic             we_ram, we_leds, we_count, we_cmp, we_ctrl, we_status;
    logic             err_evt;

    logic [9:0]       sw_meta, sw_sync;
    logic [31:0]      count, compare, count_inc;
    logic [PW-1:0]    prescaler;
    logic             tim_en, irq_en, match;
    logic             tick, match_evt;

    // Address decode. The peripheral window is checked by offset so that
    // MMIO_BASE can move without touching the register selects.
    assign off        = bus.addr - MMIO_BASE;
    assign aligned    = (bus.addr[1:0] == 2'b00);
    assign in_ram     = (bus.addr < RAM_BYTES);
    assign in_mmio    = (bus.addr >= MMIO_BASE) && (off < 32'h18);
    assign mapped     = aligned && (in_ram || in_mmio);
    assign ram_idx    = bus.addr[IDX_W+1:2];

    // RAM has priority if the two regions ever overlap.
    assign sel_leds   = mapped && !in_ram && (off[4:2] == 3'd0);
    assign sel_sw     = mapped && !in_ram && (off[4:2] == 3'd1);
    assign sel_count  = mapped && !in_ram && (off[4:2] == 3'd2);
    assign sel_cmp    = mapped && !in_ram && (off[4:2] == 3'd3);
    assign sel_ctrl   = mapped && !in_ram && (off[4:2] == 3'd4);
    assign sel_status = mapped && !in_ram && (off[4:2] == 3'd5);

    assign we_ram     = bus.ena_wr && mapped && in_ram;
    assign we_leds    = bus.ena_wr && sel_leds;
    assign we_count   = bus.ena_wr && sel_count;
    assign we_cmp     = bus.ena_wr && sel_cmp;
    assign we_ctrl    = bus.ena_wr && sel_ctrl;
    assign we_status  = bus.ena_wr && sel_status;

    // Any strobe that hits nothing is an error, and so is a store to the
    // read-only switch register.
    assign err_evt    = ((bus.ena_rd || bus.ena_wr) && !mapped) || (bus.ena_wr && sel_sw);

    // A software write to COUNT overrides the increment, so it also
    // suppresses any match that the increment would have raised.
    assign tick       = tim_en && (prescaler == PRE_LAST);
    assign count_inc  = count + 32'd1;
    assign match_evt  = tick && !we_count && (count_inc == compare);

    assign timer_irq  = match && irq_en;

    // Combinational read mux. Registers still hold their pre-edge values
    // here, which gives old-data semantics for a same-cycle read and write.
    always_comb begin
        bus.dataram_rd = '0;
        if (bus.ena_rd && mapped) begin
            if (in_ram) begin
                bus.dataram_rd = ram[ram_idx];
            end else begin
                case (off[4:2])
                    3'd0:    bus.dataram_rd = {22'd0, leds};
                    3'd1:    bus.dataram_rd = {22'd0, sw_sync};
                    3'd2:    bus.dataram_rd = count;
                    3'd3:    bus.dataram_rd = compare;
                    3'd4:    bus.dataram_rd = {30'd0, irq_en, tim_en};
                    3'd5:    bus.dataram_rd = {30'd0, bus_err, match};
                    default: bus.dataram_rd = '0;
                endcase
            end
        end
    end

    // RAM array. It is not reset, which lets it map onto block RAM.
    always_ff @(posedge CLOCK) begin
        if (we_ram) begin
            ram[ram_idx] <= bus.dataram_wr;
        end
    end

    // Peripheral registers, switch synchroniser and timer. For the sticky
    // flags a set event takes priority over a write-1-to-clear in the same cycle.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            leds      <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            count     <= '0;
            compare   <= 32'hFFFF_FFFF;
            prescaler <= '0;
            tim_en    <= 1'b0;
            irq_en    <= 1'b0;
            match     <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;

            if (we_leds) begin
                leds <= bus.dataram_wr[9:0];
            end
            if (we_cmp) begin
                compare <= bus.dataram_wr;
            end
            if (we_ctrl) begin
                tim_en <= bus.dataram_wr[0];
                irq_en <= bus.dataram_wr[1];
            end

            if (we_count) begin
                count     <= bus.dataram_wr;
                prescaler <= '0;
            end else if (tim_en) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick) begin
                    count <= count_inc;
                end
            end

            if (match_evt) begin
                match <= 1'b1;
            end else if (we_status && bus.dataram_wr[0]) begin
                match <= 1'b0;
            end

            if (err_evt) begin
                bus_err <= 1'b1;
            end else if (we_status && bus.dataram_wr[1]) begin
                bus_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio_slave.sv
// tb_dmem_mmio_slave
// Self-checking bench for dmem_mmio_slave with PRESCALE=4.
// A behavioural model of the memory map and timer predicts every load value
// and every pin state. Directed scenarios run first, then a randomized phase.
module tb_dmem_mmio_slave;

    localparam int          RAM_WORDS = 1024;
    localparam int          PRESCALE  = 4;
    localparam logic [31:0] BASE      = 32'h0001_0000;

    logic       CLOCK;
    logic       RST_n;
    logic [9:0] sw_in;
    logic [9:0] leds;
    logic       timer_irq;
    logic       bus_err;

    dmem_mmio_if bus ();

    dmem_mmio_slave #(
        .RAM_WORDS (RAM_WORDS),
        .PRESCALE  (PRESCALE),
        .MMIO_BASE (BASE)
    ) dut (
        .CLOCK     (CLOCK),
        .RST_n     (RST_n),
        .bus       (bus.slave),
        .sw_in     (sw_in),
        .leds      (leds),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] ram_m [RAM_WORDS];
    logic [9:0]  leds_m, sw_q1, sw_q2;
    logic [31:0] count_m, cmp_m;
    int          pre_m;
    bit          en_m, irqen_m, match_m, err_m;

    task automatic model_reset();
        leds_m  = '0;
        sw_q1   = '0;
        sw_q2   = '0;
        count_m = '0;
        cmp_m   = 32'hFFFF_FFFF;
        pre_m   = 0;
        en_m    = 0;
        irqen_m = 0;
        match_m = 0;
        err_m   = 0;
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return a < RAM_WORDS * 4;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h18);
    endfunction

    function automatic logic [31:0] exp_read(input bit rd, input logic [31:0] a);
        if (!rd || (a % 4) != 0) return 32'd0;
        if (is_ram(a)) return ram_m[a / 4];
        if (is_mmio(a)) begin
            case (a - BASE)
                32'h00: return {22'd0, leds_m};
                32'h04: return {22'd0, sw_q2};
                32'h08: return count_m;
                32'h0C: return cmp_m;
                32'h10: return {30'd0, irqen_m, en_m};
                32'h14: return {30'd0, err_m, match_m};
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [9:0] sw);
        bit          mapped, inc, wr_cnt, clr_m, clr_e, set_m, set_e;
        int          new_pre;
        logic [31:0] new_count;
        mapped  = ((a % 4) == 0) && (is_ram(a) || is_mmio(a));
        wr_cnt  = wr && mapped && !is_ram(a) && (a - BASE == 32'h08);
        clr_m   = wr && mapped && !is_ram(a) && (a - BASE == 32'h14) && d[0];
        clr_e   = wr && mapped && !is_ram(a) && (a - BASE == 32'h14) && d[1];
        set_e   = ((rd || wr) && !mapped) || (wr && mapped && !is_ram(a) && (a - BASE == 32'h04));
        inc     = 0;
        new_pre = pre_m;
        if (en_m) begin
            new_pre = (pre_m + 1) % PRESCALE;
            inc     = (new_pre == 0);
        end
        new_count = inc ? count_m + 32'd1 : count_m;
        set_m     = inc && !wr_cnt && (count_m + 32'd1 == cmp_m);
        if (wr && mapped) begin
            if (is_ram(a)) ram_m[a / 4] = d;
            else case (a - BASE)
                32'h00: leds_m = d[9:0];
                32'h08: begin new_count = d; new_pre = 0; end
                32'h0C: cmp_m = d;
                32'h10: begin en_m = d[0]; irqen_m = d[1]; end
                default: ;
            endcase
        end
        count_m = new_count;
        pre_m   = new_pre;
        match_m = (match_m && !clr_m) || set_m;
        err_m   = (err_m && !clr_e) || set_e;
        sw_q2   = sw_q1;
        sw_q1   = sw;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pins();
        check_output("leds", {22'd0, leds}, {22'd0, leds_m});
        check_output("timer_irq", {31'd0, timer_irq}, {31'd0, match_m && irqen_m});
        check_output("bus_err", {31'd0, bus_err}, {31'd0, err_m});
    endtask

    // One bus cycle: drive, check the combinational load value, then clock.
    task automatic apply_stimulus(input bit rd, input bit wr, input logic [31:0] a,
                                  input logic [31:0] d, input bit chk_rd);
        bus.ena_rd     = rd;
        bus.ena_wr     = wr;
        bus.addr       = a;
        bus.dataram_wr = d;
        #1;
        if (chk_rd) check_output("rd_data", bus.dataram_rd, exp_read(rd, a));
        @(posedge CLOCK);
        model_edge(rd, wr, a, d, sw_in);
        #1;
        bus.ena_rd = 1'b0;
        bus.ena_wr = 1'b0;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] a, d;
        bit          rd, wr;
        int          sel;

        RST_n          = 1'b0;
        sw_in          = '0;
        bus.ena_rd     = 1'b0;
        bus.ena_wr     = 1'b0;
        bus.addr       = '0;
        bus.dataram_wr = '0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1;
        check_pins();
        RST_n = 1'b1;

        // Reset values visible through the bus
        apply_stimulus(1, 0, BASE + 32'h08, 0, 1);
        apply_stimulus(1, 0, BASE + 32'h0C, 0, 1);
        apply_stimulus(1, 0, BASE + 32'h14, 0, 1);

        // RAM round trip and read-during-write
        apply_stimulus(0, 1, 32'h40, 32'hDEAD_BEEF, 1);
        apply_stimulus(1, 0, 32'h40, 0, 1);
        apply_stimulus(1, 1, 32'h40, 32'h1234_5678, 1);
        apply_stimulus(1, 0, 32'h40, 0, 1);

        // LEDs and switch synchroniser
        apply_stimulus(0, 1, BASE, 32'hFFFF_F2A5, 1);
        check_output("leds_2a5", {22'd0, leds}, 32'h2A5);
        apply_stimulus(1, 0, BASE, 0, 1);
        sw_in = 10'h155;
        apply_stimulus(1, 0, BASE + 32'h04, 0, 1);
        apply_stimulus(1, 0, BASE + 32'h04, 0, 1);
        apply_stimulus(1, 0, BASE + 32'h04, 0, 1);

        // Timer compare and interrupt
        apply_stimulus(0, 1, BASE + 32'h0C, 32'd3, 1);
        apply_stimulus(0, 1, BASE + 32'h10, 32'd3, 1);
        repeat (12) idle();
        check_output("irq_on", {31'd0, timer_irq}, 32'd1);
        apply_stimulus(1, 0, BASE + 32'h08, 0, 1);
        apply_stimulus(0, 1, BASE + 32'h14, 32'd1, 1);
        check_output("irq_cleared", {31'd0, timer_irq}, 32'd0);
        check_pins();

        // Wrap with no match, then COUNT write on an increment cycle
        apply_stimulus(0, 1, BASE + 32'h10, 32'd0, 1);
        apply_stimulus(0, 1, BASE + 32'h08, 32'hFFFF_FFFF, 1);
        apply_stimulus(0, 1, BASE + 32'h0C, 32'd10, 1);
        apply_stimulus(0, 1, BASE + 32'h10, 32'd1, 1);
        repeat (4) idle();
        apply_stimulus(1, 0, BASE + 32'h08, 0, 1);
        apply_stimulus(1, 0, BASE + 32'h14, 0, 1);
        for (int i = 0; i < 8 && pre_m != PRESCALE - 1; i++) idle();
        apply_stimulus(0, 1, BASE + 32'h08, 32'd5, 1);
        apply_stimulus(1, 0, BASE + 32'h08, 0, 1);
        repeat (2) idle();
        apply_stimulus(1, 0, BASE + 32'h08, 0, 1);
        apply_stimulus(1, 0, BASE + 32'h08, 0, 1);

        // Bus errors
        apply_stimulus(1, 0, 32'h0002_0000, 0, 1);
        check_output("err_set", {31'd0, bus_err}, 32'd1);
        apply_stimulus(0, 1, 32'h41, 32'hFFFF_FFFF, 1);
        apply_stimulus(1, 0, 32'h40, 0, 1);
        check_output("err_held", {31'd0, bus_err}, 32'd1);
        apply_stimulus(0, 1, BASE + 32'h14, 32'd2, 1);
        check_output("err_cleared", {31'd0, bus_err}, 32'd0);
        apply_stimulus(0, 1, BASE + 32'h04, 32'd1, 1);
        check_pins();
        apply_stimulus(0, 1, BASE + 32'h14, 32'd2, 1);

        // Asynchronous reset with the interrupt active
        apply_stimulus(0, 1, BASE + 32'h10, 32'd0, 1);
        apply_stimulus(0, 1, BASE + 32'h08, 32'd0, 1);
        apply_stimulus(0, 1, BASE + 32'h0C, 32'd2, 1);
        apply_stimulus(0, 1, BASE + 32'h10, 32'd3, 1);
        repeat (8) idle();
        apply_stimulus(1, 0, 32'h0002_0000, 0, 1);
        check_output("irq_pre_rst", {31'd0, timer_irq}, 32'd1);
        check_output("err_pre_rst", {31'd0, bus_err}, 32'd1);
        #2;
        RST_n = 1'b0;
        model_reset();
        #1;
        check_output("irq_async", {31'd0, timer_irq}, 32'd0);
        check_output("err_async", {31'd0, bus_err}, 32'd0);
        check_output("leds_async", {22'd0, leds}, 32'd0);
        @(posedge CLOCK);
        model_edge(0, 0, 0, 0, sw_in);
        model_reset();
        #1;
        RST_n = 1'b1;
        apply_stimulus(1, 0, BASE + 32'h08, 0, 1);

        // Randomized phase over a known-written RAM set plus the register window
        for (int k = 0; k < 8; k++) apply_stimulus(0, 1, 32'h40 + 32'(k * 4), $urandom, 0);
        apply_stimulus(0, 1, 32'hFFC, $urandom, 0);
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1, 2: a = 32'h40 + 32'($urandom_range(0, 7) * 4);
                3:       a = 32'hFFC;
                4:       a = 32'h1000;
                5:       a = 32'h0002_0000;
                6:       a = 32'h42;
                7:       a = BASE + 32'h09;
                8:       a = BASE + 32'h18;
                default: a = BASE + 32'((sel - 9) * 4);
            endcase
            d = $urandom;
            if (a == BASE + 32'h08 || a == BASE + 32'h0C) d = $urandom_range(0, 24);
            if (a == BASE + 32'h10) d = {30'd0, 2'($urandom_range(1, 3))};
            rd    = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 2) == 0);
            sw_in = 10'($urandom);
            apply_stimulus(rd, wr, a, d, 1);
            check_pins();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
